multi_voice_fetcher: RTL
========================

MULTI_VOICE_FETCHER -- requirements
Module: multi_voice_fetcher

Interface
REQ-001 Parameter NUM_VOICES, default 4, number of independent sample voices (legal range 1..8).
REQ-002 Parameter SAMPLE_W, default 16, signed two's-complement sample width, stored as 2 bytes per sample, little-endian; legal range 9..16.
REQ-003 Parameter ADDR_W, default 24, SPI flash byte-address width.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 trigger  input  NUM_VOICES  per-voice start request; rising-edge sensitive.
REQ-007 lrclk  input  1  I2S frame clock, synchronous to clk; a rising edge starts one fetch sweep.
REQ-008 voice_base  input  NUM_VOICES*ADDR_W  per-voice start byte address; voice v occupies bits [v*ADDR_W +: ADDR_W].
REQ-009 voice_len  input  NUM_VOICES*ADDR_W  per-voice length in samples, packed the same way as voice_base.
REQ-010 spi_data  input  8  byte returned by the SPI reader.
REQ-011 spi_data_ready  input  1  one-cycle strobe; spi_data is valid in that cycle.
REQ-012 spi_addr  output  ADDR_W  byte address of the current read request.
REQ-013 start_read  output  1  one-cycle read request pulse to the SPI reader.
REQ-014 sample_data  output  SAMPLE_W  saturated mix of all active voices for the current frame.
REQ-015 voice_active  output  NUM_VOICES  1 = voice is playing.
REQ-016 clip  output  1  1 = the last published mix saturated.
REQ-017 overrun  output  1  sticky; 1 = an lrclk rising edge arrived while a sweep was in progress.

Function
REQ-018 The block SHALL register trigger and lrclk once and detect rising edges as (current & ~previous).
REQ-019 A trigger edge SHALL set a per-voice pending bit; pending bits SHALL be applied only in IDLE, at the lrclk edge, before the sweep starts.
REQ-020 Applying pending voice v SHALL set ptr[v]=0, set active[v]=1 and clear pending[v]; if voice_len[v]==0, active[v] SHALL stay 0.
REQ-021 A retrigger of an already-active voice SHALL restart it from ptr=0; there is no queueing.
REQ-022 FSM states are IDLE, SELECT, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, ACCUM and PUBLISH; the reset state is IDLE.
REQ-023 IDLE->SELECT on an lrclk rising edge; the accumulator is cleared and the voice index is set to 0.
REQ-024 SELECT: if active[idx], go to REQ_LO; else if idx==NUM_VOICES-1, go to PUBLISH; else increment idx and stay in SELECT.
REQ-025 REQ_LO: start_read=1 for exactly one cycle with spi_addr = voice_base[idx] + 2*ptr[idx], computed modulo 2^ADDR_W; then go to WAIT_LO.
REQ-026 WAIT_LO: on spi_data_ready, latch the low byte and go to REQ_HI; REQ_HI/WAIT_HI behave the same way at address+1 for the high byte.
REQ-027 spi_data_ready SHALL be ignored outside the WAIT_LO and WAIT_HI states.
REQ-028 ACCUM: take the low SAMPLE_W bits of {hi,lo}, sign-extend them to SAMPLE_W+3 bits, add to the accumulator and increment ptr[idx].
REQ-029 ACCUM end of sample: if the old ptr[idx] == voice_len[idx]-1, clear active[idx]; this sample is still mixed.
REQ-030 ACCUM exit: go to PUBLISH if idx==NUM_VOICES-1, otherwise increment idx and go to SELECT.
REQ-031 PUBLISH: clamp the accumulator to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1], register the result to sample_data and set clip=1 iff clamping occurred; then go to IDLE.
REQ-032 sample_data and clip SHALL hold their values between PUBLISH states; a sweep with no active voices SHALL publish 0 with clip=0.
REQ-033 An lrclk edge outside IDLE SHALL set overrun=1 and SHALL be dropped; the current sweep completes normally.
REQ-034 A trigger edge arriving during a sweep SHALL NOT affect that sweep.
REQ-035 start_read SHALL never be asserted in any state except REQ_LO and REQ_HI.

Reset
REQ-036 While reset==0 at a clk edge, the block SHALL force the following, regardless of state, including mid-transfer: state=IDLE; sample_data=0; start_read=0; spi_addr=0; voice_active=0; pending=0; all ptr=0; clip=0; overrun=0; edge-detect registers=0.
REQ-037 After reset, the first lrclk edge SHALL be detected only if lrclk was sampled low at least one cycle after reset release.

Verification
REQ-038 NUM_VOICES=4, voice 0 base=0x000100, len=3; pulse trig0, then 3 lrclk edges, flash returns samples 0x0010, 0x0020, 0x0030 -> reads at 0x100/0x101, 0x102/0x103, 0x104/0x105; sample_data=0x0010, 0x0020, 0x0030; voice_active[0]=0 after the third sweep; the fourth sweep publishes 0.
REQ-039 Voices 0 and 1 active, samples 0x7000 and 0x2000 -> sample_data=0x7FFF, clip=1; with samples 0x9000 and 0xA000 -> sample_data=0x8000, clip=1; with 0x0100 and 0xFF00 -> sample_data=0x0000, clip=0.
REQ-040 Retrigger voice 2 at ptr=5 -> the next sweep reads voice_base[2]+0; a trigger edge during WAIT_HI of voice 2 does not change that sweep's address.
REQ-041 Hold spi_data_ready low for 200 cycles with lrclk toggling -> overrun=1, exactly one start_read outstanding, no extra reads; overrun stays 1 until reset.
REQ-042 Assert reset in WAIT_LO -> next cycle state=IDLE and all outputs 0; stale spi_data_ready strobes afterwards are ignored; voice_len=0 plus trigger -> voice_active stays 0.
REQ-043 voice_base=0xFFFFFE, len=2 -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001 (wrap-around).

Source files
------------

// File: rtl/multi_voice_fetcher.sv
// Multi-voice sample fetcher: per lrclk frame, reads one 16-bit sample per
// active voice from SPI flash, mixes them and publishes a saturated result.
module multi_voice_fetcher #(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 16,
    parameter int ADDR_W     = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_VOICES-1:0]        trigger,
    input  logic                         lrclk,
    input  logic [NUM_VOICES*ADDR_W-1:0] voice_base,
    input  logic [NUM_VOICES*ADDR_W-1:0] voice_len,
    input  logic [7:0]                   spi_data,
    input  logic                         spi_data_ready,
    output logic [ADDR_W-1:0]            spi_addr,
    output logic                         start_read,
    output logic [SAMPLE_W-1:0]          sample_data,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic                         clip,
    output logic                         overrun
);

    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W  = SAMPLE_W + 3;
    localparam int SMAX_I = (1 << (SAMPLE_W - 1)) - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(SMAX_I);
    localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-SMAX_I - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_REQ_LO, S_WAIT_LO,
        S_REQ_HI, S_WAIT_HI, S_ACCUM, S_PUBLISH
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [7:0]               lo_q, lo_d, hi_q, hi_d;
    logic [ADDR_W-1:0]        ptr_q [NUM_VOICES];
    logic [ADDR_W-1:0]        ptr_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]    active_q, active_d;
    logic [NUM_VOICES-1:0]    pend_q, pend_d;
    logic [NUM_VOICES-1:0]    trig_q, trig_d;
    logic                     lrclk_q, lrclk_d;
    logic                     lr_arm_q, lr_arm_d;
    logic [ADDR_W-1:0]        spi_addr_q, spi_addr_d;
    logic [SAMPLE_W-1:0]      sample_q, sample_d;
    logic                     clip_q, clip_d;
    logic                     overrun_q, overrun_d;

    logic [NUM_VOICES-1:0]    trig_edge;
    logic                     lr_edge;
    logic [ADDR_W-1:0]        base_sel, len_sel, ptr_sel;
    logic [15:0]              word;
    logic [SAMPLE_W-1:0]      samp;
    logic signed [ACC_W-1:0]  samp_ext;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        ptr_d      = ptr_q;
        active_d   = active_q;
        spi_addr_d = spi_addr_q;
        sample_d   = sample_q;
        clip_d     = clip_q;
        overrun_d  = overrun_q;

        trig_d    = trigger;
        lrclk_d   = lrclk;
        // lrclk must be seen low after reset before a rising edge counts
        lr_arm_d  = lr_arm_q | ~lrclk;
        trig_edge = trigger & ~trig_q;
        lr_edge   = lrclk & ~lrclk_q & lr_arm_q;
        pend_d    = pend_q | trig_edge;

        base_sel = voice_base[idx_q*ADDR_W +: ADDR_W];
        len_sel  = voice_len[idx_q*ADDR_W +: ADDR_W];
        ptr_sel  = ptr_q[idx_q];
        word     = {hi_q, lo_q};
        samp     = word[SAMPLE_W-1:0];
        samp_ext = {{3{samp[SAMPLE_W-1]}}, samp};

        unique case (state_q)
            S_IDLE: begin
                if (lr_edge) begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (pend_q[v]) begin
                            ptr_d[v]    = '0;
                            active_d[v] = (voice_len[v*ADDR_W +: ADDR_W] != '0);
                            pend_d[v]   = trig_edge[v];
                        end
                    end
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (active_q[idx_q]) begin
                    spi_addr_d = base_sel + {ptr_sel[ADDR_W-2:0], 1'b0};
                    state_d    = S_REQ_LO;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_PUBLISH;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_REQ_LO: state_d = S_WAIT_LO;
            S_WAIT_LO: begin
                if (spi_data_ready) begin
                    lo_d       = spi_data;
                    spi_addr_d = spi_addr_q + 1'b1;
                    state_d    = S_REQ_HI;
                end
            end
            S_REQ_HI: state_d = S_WAIT_HI;
            S_WAIT_HI: begin
                if (spi_data_ready) begin
                    hi_d    = spi_data;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d        = acc_q + samp_ext;
                ptr_d[idx_q] = ptr_sel + 1'b1;
                if (ptr_sel == len_sel - 1'b1) active_d[idx_q] = 1'b0;
                if (idx_q == LAST_IDX) begin
                    state_d = S_PUBLISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_SELECT;
                end
            end
            S_PUBLISH: begin
                if (acc_q > SMAX) begin
                    sample_d = SMAX[SAMPLE_W-1:0];
                    clip_d   = 1'b1;
                end else if (acc_q < SMIN) begin
                    sample_d = SMIN[SAMPLE_W-1:0];
                    clip_d   = 1'b1;
                end else begin
                    sample_d = acc_q[SAMPLE_W-1:0];
                    clip_d   = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (lr_edge && state_q != S_IDLE) overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            for (int v = 0; v < NUM_VOICES; v++) ptr_q[v] <= '0;
            active_q   <= '0;
            pend_q     <= '0;
            trig_q     <= '0;
            lrclk_q    <= 1'b0;
            lr_arm_q   <= 1'b0;
            spi_addr_q <= '0;
            sample_q   <= '0;
            clip_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            ptr_q      <= ptr_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            trig_q     <= trig_d;
            lrclk_q    <= lrclk_d;
            lr_arm_q   <= lr_arm_d;
            spi_addr_q <= spi_addr_d;
            sample_q   <= sample_d;
            clip_q     <= clip_d;
            overrun_q  <= overrun_d;
        end
    end

    assign start_read   = (state_q == S_REQ_LO) || (state_q == S_REQ_HI);
    assign spi_addr     = spi_addr_q;
    assign sample_data  = sample_q;
    assign voice_active = active_q;
    assign clip         = clip_q;
    assign overrun      = overrun_q;

endmodule
